// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution window sequencer.
// Optional output ReLU is enabled by defining CONV_SEQ_RELU_EN.
package conv_pkg;

    localparam int PSUM_W = 32;

    typedef logic signed [1:0] tern_t;
    typedef logic signed [PSUM_W-1:0] psum_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        OUT,
        DONE
    } seq_state_t;

    // Counter/address widths never collapse to zero bits (e.g. K=1).
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Window/tap counters for the sequencer.
// Produces row-major IFM and weight addresses for the current tap.
module conv_addr_gen #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int K     = 3,
    parameter int AW    = conv_pkg::clog2_min1(IMG_W * IMG_H),
    parameter int WW    = conv_pkg::clog2_min1(K * K),
    parameter int RW    = conv_pkg::clog2_min1(IMG_H),
    parameter int CW    = conv_pkg::clog2_min1(IMG_W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          step,
    input  logic          next_pixel,
    output logic          last_tap,
    output logic          last_pixel,
    output logic [AW-1:0] ifm_addr,
    output logic [WW-1:0] wgt_addr,
    output logic [RW-1:0] orow,
    output logic [CW-1:0] ocol
);
    import conv_pkg::*;

    localparam int KW = clog2_min1(K);
    localparam int OH = IMG_H - K + 1;
    localparam int OW = IMG_W - K + 1;

    logic [KW-1:0] kr;
    logic [KW-1:0] kc;

    assign last_tap   = (kr == KW'(K - 1)) && (kc == KW'(K - 1));
    assign last_pixel = (orow == RW'(OH - 1)) && (ocol == CW'(OW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kr   <= '0;
            kc   <= '0;
            orow <= '0;
            ocol <= '0;
        end else if (clr) begin
            kr   <= '0;
            kc   <= '0;
            orow <= '0;
            ocol <= '0;
        end else begin
            // Tap walk wraps to (0,0) after the last tap, ready for the next pixel.
            if (step) begin
                if (kc == KW'(K - 1)) begin
                    kc <= '0;
                    kr <= (kr == KW'(K - 1)) ? '0 : kr + KW'(1);
                end else begin
                    kc <= kc + KW'(1);
                end
            end
            if (next_pixel) begin
                if (ocol == CW'(OW - 1)) begin
                    ocol <= '0;
                    orow <= (orow == RW'(OH - 1)) ? '0 : orow + RW'(1);
                end else begin
                    ocol <= ocol + CW'(1);
                end
            end
        end
    end

    assign ifm_addr = AW'((int'(orow) + int'(kr)) * IMG_W
                          + int'(ocol) + int'(kc));
    assign wgt_addr = WW'(int'(kr) * K + int'(kc));

endmodule

// File: rtl/conv_window_sequencer.sv
// Walks a KxK window per output pixel, feeds the external PE, streams results.
// Define CONV_SEQ_RELU_EN to clamp negative results to zero on out_data.
module conv_window_sequencer #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int PSUM_W = conv_pkg::PSUM_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    ifm_rd_en,
    output logic [conv_pkg::clog2_min1(IMG_W*IMG_H)-1:0] ifm_addr,
    input  logic signed [1:0]       ifm_rdata,
    output logic [conv_pkg::clog2_min1(K*K)-1:0] wgt_addr,
    input  logic signed [1:0]       wgt_rdata,
    output logic signed [PSUM_W-1:0] pe_inpsum,
    output logic signed [1:0]       pe_weight,
    output logic signed [1:0]       pe_infmap,
    input  logic signed [PSUM_W-1:0] pe_outpsum,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [PSUM_W-1:0] out_data,
    output logic [conv_pkg::clog2_min1(IMG_H)-1:0] out_row,
    output logic [conv_pkg::clog2_min1(IMG_W)-1:0] out_col
);
    import conv_pkg::*;

    localparam int AW = clog2_min1(IMG_W * IMG_H);
    localparam int WW = clog2_min1(K * K);
    localparam int RW = clog2_min1(IMG_H);
    localparam int CW = clog2_min1(IMG_W);

    seq_state_t state;

    logic signed [PSUM_W-1:0] acc;
    logic signed [PSUM_W-1:0] res;
    logic land;
    logic clr;
    logic step;
    logic next_pixel;
    logic last_tap;
    logic last_pixel;

    assign clr        = (state == IDLE) && start;
    assign step       = (state == FETCH);
    assign next_pixel = (state == OUT) && out_ready;

    conv_addr_gen #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .K    (K),
        .AW   (AW),
        .WW   (WW),
        .RW   (RW),
        .CW   (CW)
    ) u_addr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .step      (step),
        .next_pixel(next_pixel),
        .last_tap  (last_tap),
        .last_pixel(last_pixel),
        .ifm_addr  (ifm_addr),
        .wgt_addr  (wgt_addr),
        .orow      (out_row),
        .ocol      (out_col)
    );

    // Buffer data is only meaningful in the cycle after a read strobe.
    assign pe_weight = land ? wgt_rdata : '0;
    assign pe_infmap = land ? ifm_rdata : '0;
    assign pe_inpsum = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            ifm_rd_en <= 1'b0;
            out_valid <= 1'b0;
            land      <= 1'b0;
            acc       <= '0;
        end else begin
            land <= (state == FETCH);
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FETCH;
                        busy      <= 1'b1;
                        ifm_rd_en <= 1'b1;
                        acc       <= '0;
                    end
                end
                FETCH: begin
                    if (last_tap) begin
                        state     <= DRAIN;
                        ifm_rd_en <= 1'b0;
                    end
                end
                DRAIN: begin
                    state     <= OUT;
                    out_valid <= 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        if (last_pixel) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state     <= FETCH;
                            ifm_rd_en <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (land) begin
                acc <= pe_outpsum;
            end
        end
    end

    always_comb begin
        res = acc;
`ifdef CONV_SEQ_RELU_EN
        if (acc[PSUM_W-1]) begin
            res = '0;
        end
`endif
        out_data = out_valid ? res : '0;
    end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench: a 4x4/K=3 build and a 2x2/K=1 build of the sequencer.
// Buffer and PE models live here; ReLU expectations follow CONV_SEQ_RELU_EN.
`timescale 1ns/1ps
module tb_conv_window_sequencer;

`ifdef CONV_SEQ_RELU_EN
    localparam int NEG9 = 0;
    localparam int NEG1 = 0;
`else
    localparam int NEG9 = -9;
    localparam int NEG1 = -1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        start_a, busy_a, done_a, rd_a, valid_a, ready_a;
    logic [3:0]  iaddr_a, waddr_a;
    logic [1:0]  row_a, col_a;
    logic signed [1:0]  irdata_a = '0, wrdata_a = '0, pew_a, pex_a;
    logic signed [31:0] inps_a, outps_a, data_a;
    logic signed [1:0]  ifm_a [16];
    logic signed [1:0]  wgt_a [9];

    logic        start_b, busy_b, done_b, rd_b, valid_b, ready_b;
    logic [1:0]  iaddr_b;
    logic [0:0]  waddr_b, row_b, col_b;
    logic signed [1:0]  irdata_b = '0, wrdata_b = '0, pew_b, pex_b;
    logic signed [31:0] inps_b, outps_b, data_b;
    logic signed [1:0]  ifm_b [4];
    logic signed [1:0]  wgt_b [1];

    conv_window_sequencer #(
        .IMG_W(4), .IMG_H(4), .K(3), .PSUM_W(32)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .busy(busy_a), .done(done_a),
        .ifm_rd_en(rd_a), .ifm_addr(iaddr_a), .ifm_rdata(irdata_a),
        .wgt_addr(waddr_a), .wgt_rdata(wrdata_a),
        .pe_inpsum(inps_a), .pe_weight(pew_a), .pe_infmap(pex_a),
        .pe_outpsum(outps_a),
        .out_valid(valid_a), .out_ready(ready_a), .out_data(data_a),
        .out_row(row_a), .out_col(col_a)
    );

    conv_window_sequencer #(
        .IMG_W(2), .IMG_H(2), .K(1), .PSUM_W(32)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .busy(busy_b), .done(done_b),
        .ifm_rd_en(rd_b), .ifm_addr(iaddr_b), .ifm_rdata(irdata_b),
        .wgt_addr(waddr_b), .wgt_rdata(wrdata_b),
        .pe_inpsum(inps_b), .pe_weight(pew_b), .pe_infmap(pex_b),
        .pe_outpsum(outps_b),
        .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b),
        .out_row(row_b), .out_col(col_b)
    );

    // Registered-read buffers, one cycle latency.
    always @(posedge clk) begin
        if (rd_a) begin
            irdata_a <= ifm_a[iaddr_a];
            wrdata_a <= wgt_a[waddr_a];
        end
        if (rd_b) begin
            irdata_b <= ifm_b[iaddr_b];
            wrdata_b <= wgt_b[waddr_b];
        end
    end

    // PE: zero infmap forces a zero result.
    assign outps_a = (pex_a == 2'sd0) ? '0
                   : inps_a + int'(pew_a) * int'(pex_a);
    assign outps_b = (pex_b == 2'sd0) ? '0
                   : inps_b + int'(pew_b) * int'(pex_b);

    int done_cnt_a = 0;
    int done_cnt_b = 0;
    always @(posedge clk) begin
        if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
        if (done_b === 1'b1) done_cnt_b <= done_cnt_b + 1;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string tag,
                         input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill_a(input logic signed [1:0] iv,
                          input logic signed [1:0] wv);
        for (int i = 0; i < 16; i++) ifm_a[i] = iv;
        for (int i = 0; i < 9; i++) wgt_a[i] = wv;
    endtask

    task automatic go(input bit b);
        if (b) start_b = 1'b1;
        else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic pixel(input bit b, input string tag,
                         input int d, input int r, input int c);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while ((b ? valid_b : valid_a) !== 1'b1 && lat < 60);
        check({tag, ".valid"}, b ? valid_b : valid_a, 1);
        check({tag, ".lat"}, lat, b ? 3 : 11);
        check({tag, ".data"}, b ? data_b : data_a, d);
        check({tag, ".row"}, b ? 2'(row_b) : row_a, r);
        check({tag, ".col"}, b ? 2'(col_b) : col_a, c);
    endtask

    task automatic finish(input bit b, input string tag);
        @(negedge clk);
        check({tag, ".done"}, b ? done_b : done_a, 1);
        check({tag, ".busy"}, b ? busy_b : busy_a, 0);
        @(negedge clk);
        check({tag, ".done_clr"}, b ? done_b : done_a, 0);
    endtask

    initial begin
        int base;
        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        ready_a = 1'b1;
        ready_b = 1'b1;
        fill_a(2'sd1, 2'sd1);
        ifm_b[0] = 2'b01;
        ifm_b[1] = 2'b11;
        ifm_b[2] = 2'b00;
        ifm_b[3] = 2'b01;
        wgt_b[0] = 2'b11;

        repeat (2) @(negedge clk);
        check("rst.a_ctl", {busy_a, done_a, rd_a, valid_a, iaddr_a,
                            waddr_a, row_a, col_a, pew_a, pex_a}, 0);
        check("rst.a_inpsum", inps_a, 0);
        check("rst.a_data", data_a, 0);
        check("rst.b_ctl", {busy_b, done_b, rd_b, valid_b, iaddr_b,
                            waddr_b, row_b, col_b, data_b}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle.a", {busy_a, done_a, rd_a, valid_a}, 0);

        // All-ones window sums to 9 at every position.
        base = done_cnt_a;
        go(0);
        pixel(0, "t1p0", 9, 0, 0);
        check("t1.busy", busy_a, 1);
        pixel(0, "t1p1", 9, 0, 1);
        pixel(0, "t1p2", 9, 1, 0);
        pixel(0, "t1p3", 9, 1, 1);
        finish(0, "t1");
        check("t1.done_cnt", done_cnt_a - base, 1);

        fill_a(2'b11, 2'sd1);
        go(0);
        pixel(0, "t2p0", NEG9, 0, 0);
        pixel(0, "t2p1", NEG9, 0, 1);
        pixel(0, "t2p2", NEG9, 1, 0);
        pixel(0, "t2p3", NEG9, 1, 1);
        finish(0, "t2");

        fill_a(2'sd0, 2'sd1);
        go(0);
        pixel(0, "t3p0", 0, 0, 0);
        pixel(0, "t3p1", 0, 0, 1);
        pixel(0, "t3p2", 0, 1, 0);
        pixel(0, "t3p3", 0, 1, 1);
        finish(0, "t3");

        // Column/row-dependent IFM with one -1 weight at (0,1).
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                ifm_a[r*4+c] = ((c == 1) ^ (r == 3)) ? 2'b11 : 2'b01;
        for (int i = 0; i < 9; i++) wgt_a[i] = (i == 1) ? 2'b11 : 2'b01;
        go(0);
        pixel(0, "t7p0", 5, 0, 0);
        pixel(0, "t7p1", 1, 0, 1);
        pixel(0, "t7p2", 3, 1, 0);
        pixel(0, "t7p3", NEG1, 1, 1);
        finish(0, "t7");

        fill_a(2'sd1, 2'sd1);
        ready_a = 1'b0;
        go(0);
        pixel(0, "t4p0", 9, 0, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t4.stall", {valid_a, rd_a, row_a, col_a, data_a},
                  {1'b1, 1'b0, 2'd0, 2'd0, 32'd9});
        end
        ready_a = 1'b1;
        pixel(0, "t4p1", 9, 0, 1);
        pixel(0, "t4p2", 9, 1, 0);
        pixel(0, "t4p3", 9, 1, 1);
        finish(0, "t4");

        base = done_cnt_a;
        go(0);
        repeat (3) @(negedge clk);
        check("t5.midfetch", rd_a, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5.rst_ctl", {busy_a, done_a, rd_a, valid_a, iaddr_a,
                             waddr_a, row_a, col_a, pew_a, pex_a}, 0);
        check("t5.rst_inpsum", inps_a, 0);
        check("t5.rst_data", data_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t5.no_done", done_cnt_a - base, 0);
        check("t5.idle", {busy_a, rd_a, valid_a}, 0);
        go(0);
        pixel(0, "t5p0", 9, 0, 0);
        pixel(0, "t5p1", 9, 0, 1);
        pixel(0, "t5p2", 9, 1, 0);
        pixel(0, "t5p3", 9, 1, 1);
        finish(0, "t5");
        check("t5.done_cnt", done_cnt_a - base, 1);

        // K=1 build; a start during the frame must be ignored.
        base = done_cnt_b;
        go(1);
        pixel(1, "t6p0", NEG1, 0, 0);
        go(1);
        pixel(1, "t6p1", 1, 0, 1);
        pixel(1, "t6p2", 0, 1, 0);
        pixel(1, "t6p3", NEG1, 1, 1);
        finish(1, "t6");
        repeat (10) @(negedge clk);
        check("t6.idle", {busy_b, rd_b, valid_b}, 0);
        check("t6.done_cnt", done_cnt_b - base, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
